// File: rtl/control_fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding and PC defaults used by the
// fetch controller, instruction memory and IF/ID register.
package control_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    HALT   = 2'd3
  } fetch_state_t;

  localparam int FETCH_PC_W     = 7;
  localparam int FETCH_RESET_PC = 0;

endpackage

// File: rtl/control_fetch_sumador.sv
// sumador: fixed 7-bit PC incrementer, wraps 127 -> 0.
module sumador (
  input  logic [6:0] a,
  output logic [6:0] s
);

  assign s = a + 7'd1;

endmodule

// File: rtl/control_fetch.sv
// Fetch-stage PC sequencer: owns the PC, picks next PC from increment /
// redirect / hold, inserts post-redirect bubbles and drives IF/ID valid/flush.
module control_fetch
  import control_fetch_pkg::*;
#(
  parameter int PC_W     = FETCH_PC_W,
  parameter int RESET_PC = FETCH_RESET_PC,
  parameter int BUBBLES  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_inc_o,
  output logic            valid_o,
  output logic            flush_o,
  output logic            halted_o
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [1:0]      cnt, cnt_nxt;

  generate
    if (PC_W == 7) begin : g_sumador
      sumador u_inc (.a(pc_o), .s(pc_inc_o));
    end else begin : g_inline_inc
      assign pc_inc_o = pc_o + PC_W'(1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_o  <= PC_W'(RESET_PC);
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      pc_o  <= pc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_o;
    cnt_nxt   = cnt;
    flush_o   = 1'b0;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN, BUBBLE: begin
        if (branch_taken_i) begin
          pc_nxt    = branch_target_i;
          flush_o   = 1'b1;
          state_nxt = BUBBLE;
          cnt_nxt   = 2'(BUBBLES - 1);
        end else if (halt_i && state == RUN) begin
          state_nxt = HALT;
        end else if (!stall_i) begin
          pc_nxt = pc_inc_o;
          // counter==0 marks the last bubble cycle; BUBBLES-1 start gives BUBBLES invalid cycles
          if (state == BUBBLE) begin
            if (cnt == 2'd0) state_nxt = RUN;
            else             cnt_nxt   = cnt - 2'd1;
          end
        end
      end
      HALT: ;
      default: state_nxt = BOOT;
    endcase
  end

  assign valid_o  = (state == RUN) & ~stall_i & ~branch_taken_i & ~halt_i;
  assign halted_o = (state == HALT);

endmodule

// File: tb/tb_control_fetch.sv
// Directed bench for control_fetch (PC_W=7, RESET_PC=0, BUBBLES=2).
module tb_control_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall_i, branch_taken_i, halt_i;
  logic [6:0] branch_target_i;
  logic [6:0] pc_o, pc_inc_o;
  logic       valid_o, flush_o, halted_o;

  int n_chk  = 0;
  int n_fail = 0;

  control_fetch #(.PC_W(7), .RESET_PC(0), .BUBBLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .halt_i(halt_i), .pc_o(pc_o), .pc_inc_o(pc_inc_o),
    .valid_o(valid_o), .flush_o(flush_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  // inputs change 1ns after the edge, outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_to(input logic [6:0] target);
    int n = 0;
    while (pc_o !== target && n < 200) begin tick(); n++; end
    n_chk++;
    if (pc_o !== target) begin n_fail++; $display("FAIL run_to timeout: pc=%0d required %0d", pc_o, target); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 0; branch_taken_i = 0; halt_i = 0; branch_target_i = '0;
    tick(); tick(); #1;
    n_chk++; if (pc_o !== 7'd0)   begin n_fail++; $display("FAIL reset_pc: pc=%0d required 0", pc_o); end
    n_chk++; if (valid_o !== 1'b0 || flush_o !== 1'b0 || halted_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: v=%b f=%b h=%b required 000", valid_o, flush_o, halted_o); end
    rst_n = 1'b1; #1;
    n_chk++; if (valid_o !== 1'b0 || pc_o !== 7'd0) begin
      n_fail++; $display("FAIL boot: pc=%0d v=%b required pc=0 v=0", pc_o, valid_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (pc_o !== 7'(i) || valid_o !== 1'b1) begin
        n_fail++; $display("FAIL run_seq%0d: pc=%0d v=%b required pc=%0d v=1", i, pc_o, valid_o, i); end
      tick();
    end
  endtask

  task automatic test_stall();
    run_to(7'd5);
    n_chk++; if (pc_inc_o !== 7'd6) begin n_fail++; $display("FAIL pc_inc5: got %0d required 6", pc_inc_o); end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (pc_o !== 7'd5 || valid_o !== 1'b0) begin
        n_fail++; $display("FAIL stall%0d: pc=%0d v=%b required pc=5 v=0", i, pc_o, valid_o); end
      tick();
    end
    stall_i = 1'b0; #1;
    n_chk++; if (pc_o !== 7'd5 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: pc=%0d v=%b required pc=5 v=1", pc_o, valid_o); end
    tick();
    n_chk++; if (pc_o !== 7'd6) begin n_fail++; $display("FAIL after_stall: pc=%0d required 6", pc_o); end
  endtask

  task automatic test_branch();
    run_to(7'd10);
    branch_taken_i = 1'b1; branch_target_i = 7'd40; #1;
    n_chk++; if (flush_o !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL branch_flush: f=%b v=%b required f=1 v=0", flush_o, valid_o); end
    tick(); branch_taken_i = 1'b0; #1;
    n_chk++; if (pc_o !== 7'd40 || valid_o !== 1'b0 || flush_o !== 1'b0) begin
      n_fail++; $display("FAIL bubble1: pc=%0d v=%b f=%b required 40/0/0", pc_o, valid_o, flush_o); end
    tick();
    n_chk++; if (pc_o !== 7'd41 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bubble2: pc=%0d v=%b required 41/0", pc_o, valid_o); end
    tick();
    n_chk++; if (pc_o !== 7'd42 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL post_bubble: pc=%0d v=%b required 42/1", pc_o, valid_o); end
  endtask

  task automatic test_branch_stall();
    run_to(7'd20);
    branch_taken_i = 1'b1; stall_i = 1'b1; branch_target_i = 7'd3; #1;
    n_chk++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL br_stall_flush: f=%b required 1", flush_o); end
    tick(); branch_taken_i = 1'b0; stall_i = 1'b0; #1;
    n_chk++; if (pc_o !== 7'd3 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL br_stall_pc: pc=%0d v=%b required 3/0", pc_o, valid_o); end
    tick();
    branch_taken_i = 1'b1; branch_target_i = 7'd50; #1;
    n_chk++; if (pc_o !== 7'd4 || flush_o !== 1'b1) begin
      n_fail++; $display("FAIL br_in_bubble: pc=%0d f=%b required 4/1", pc_o, flush_o); end
    tick(); branch_taken_i = 1'b0; #1;
    n_chk++; if (pc_o !== 7'd50 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL restart1: pc=%0d v=%b required 50/0", pc_o, valid_o); end
    tick();
    n_chk++; if (pc_o !== 7'd51 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL restart2: pc=%0d v=%b required 51/0", pc_o, valid_o); end
    tick();
    n_chk++; if (pc_o !== 7'd52 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL restart_done: pc=%0d v=%b required 52/1", pc_o, valid_o); end
  endtask

  task automatic test_wrap_halt();
    run_to(7'd126);
    tick();
    n_chk++; if (pc_o !== 7'd127 || pc_inc_o !== 7'd0) begin
      n_fail++; $display("FAIL wrap127: pc=%0d inc=%0d required 127/0", pc_o, pc_inc_o); end
    tick();
    n_chk++; if (pc_o !== 7'd0 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL wrap0: pc=%0d v=%b required 0/1", pc_o, valid_o); end
    tick(); tick();
    halt_i = 1'b1; #1;
    n_chk++; if (pc_o !== 7'd2 || valid_o !== 1'b0 || halted_o !== 1'b0) begin
      n_fail++; $display("FAIL halt_req: pc=%0d v=%b h=%b required 2/0/0", pc_o, valid_o, halted_o); end
    tick(); halt_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 7'd9; stall_i = 1'b1; #1;
    n_chk++; if (pc_o !== 7'd2 || halted_o !== 1'b1 || valid_o !== 1'b0 || flush_o !== 1'b0) begin
      n_fail++; $display("FAIL halted: pc=%0d h=%b v=%b f=%b required 2/1/0/0", pc_o, halted_o, valid_o, flush_o); end
    tick(); tick(); branch_taken_i = 1'b0; stall_i = 1'b0;
    n_chk++; if (pc_o !== 7'd2 || halted_o !== 1'b1) begin
      n_fail++; $display("FAIL halt_frozen: pc=%0d h=%b required 2/1", pc_o, halted_o); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    n_chk++; if (pc_o !== 7'd0 || halted_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_halt: pc=%0d h=%b v=%b required 0/0/0", pc_o, halted_o, valid_o); end
    tick();
    n_chk++; if (pc_o !== 7'd0 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_halt_run: pc=%0d v=%b required 0/1", pc_o, valid_o); end
    branch_taken_i = 1'b1; branch_target_i = 7'd40;
    tick(); branch_taken_i = 1'b0; tick();
    n_chk++; if (pc_o !== 7'd41 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL pre_rst_bubble: pc=%0d v=%b required 41/0", pc_o, valid_o); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    n_chk++; if (pc_o !== 7'd0 || valid_o !== 1'b0 || halted_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_bubble: pc=%0d v=%b h=%b required 0/0/0", pc_o, valid_o, halted_o); end
    tick();
    n_chk++; if (pc_o !== 7'd0 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_bubble_run0: pc=%0d v=%b required 0/1", pc_o, valid_o); end
    tick();
    n_chk++; if (pc_o !== 7'd1 || valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_bubble_run1: pc=%0d v=%b required 1/1", pc_o, valid_o); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
